dmem_port_arbiter: RTL

//  Shares the single data-memory port between the pipeline MEM stage (core) and an

---
 rtl/dmem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: the MEM stage (core) has priority, a debug/loader requester is
// granted when the core is idle or after MAX_WAIT blocked cycles. Optional perf counters via DMEM_ARB_PERF_EN.
module dmem_port_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_func3,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    input  logic                  dbg_valid,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_func3,
    output logic                  dbg_ready,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]           perf_stall_cnt,
    output logic [15:0]           perf_dbg_cnt
`endif
);

    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic {
        OWN_CORE,
        OWN_DBG
    } owner_e;

    owner_e        owner;
    logic          core_req;
    logic          starve;
    logic          dbg_xfer;
    logic [CW-1:0] wait_cnt;

    assign core_req   = core_rd | core_wr;
    assign starve     = (wait_cnt == WAIT_MAX);
    assign owner      = (!reset && dbg_valid && (!core_req || starve)) ? OWN_DBG : OWN_CORE;
    // Ownership already requires dbg_valid, so a grant is always a completed handshake.
    assign dbg_xfer   = (owner == OWN_DBG);
    assign core_rdata = mem_rdata;

    always_comb begin
        // NOTE: every output gets a default first so no path can leave one unassigned (no latches).
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_func3  = '0;
        dbg_ready  = 1'b0;
        core_stall = 1'b0;
        if (owner == OWN_DBG) begin
            mem_rd     = !dbg_we;
            mem_wr     = dbg_we;
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
            mem_func3  = dbg_func3;
            dbg_ready  = 1'b1;
            core_stall = core_req;
        end else if (!reset) begin
            mem_rd     = core_rd;
            mem_wr     = core_wr;
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
            mem_func3  = core_func3;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge.
        if (reset) begin
            wait_cnt   <= '0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            if (!dbg_valid || dbg_xfer) begin
                wait_cnt <= '0;
            end else if (!starve) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            dbg_rvalid <= dbg_xfer && !dbg_we;
            if (dbg_xfer && !dbg_we) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_dbg_cnt   <= '0;
        end else begin
            if (core_stall) perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (dbg_xfer)   perf_dbg_cnt   <= perf_dbg_cnt + 16'd1;
        end
    end
`endif

endmodule
